// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: hex-to-segment table,
// segment bit positions and the lookup helper.
package seven_seg_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Entry h is the abcdefgh pattern for hex digit h, dp cleared.
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
   };

   function automatic logic [7:0] hex_to_seg(logic [3:0] h);
      return SEG_LUT[h];
   endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle: value/dot/control inputs from the producer and
// the multiplexed segment/digit outputs toward the board.
interface seven_seg_scan_if #(
   parameter int DIGIT = 4
);
   logic               en;
   logic               blank_lz;
   logic [4*DIGIT-1:0] number;
   logic [DIGIT-1:0]   dots;
   logic [7:0]         abcdefgh;
   logic [DIGIT-1:0]   digit;

   modport master (
      output en, blank_lz, number, dots,
      input  abcdefgh, digit
   );

   modport slave (
      input  en, blank_lz, number, dots,
      output abcdefgh, digit
   );
endinterface

// File: rtl/strobe_gen.sv
// Free-running 0..PERIOD-1 counter; tick is high for the single cycle in
// which the count sits at PERIOD-1.
module strobe_gen #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver: one digit per tick, value/dots latched
// only when the scan wraps to digit 0; outputs registered one cycle after tick.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int CLK       = 100,
   parameter int DIGIT     = 4,
   parameter int UPDATE_HZ = 1000
) (
   input  logic            clk,
   input  logic            rst,
   seven_seg_scan_if.slave bus
);
   localparam int TICK_MAX = CLK * 1_000_000 / UPDATE_HZ;
   localparam int IDX_W    = (DIGIT > 1) ? $clog2(DIGIT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGIT - 1);

   logic tick;

   strobe_gen #(.PERIOD(TICK_MAX)) u_strobe (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [4*DIGIT-1:0] shadow_q, shadow_d;
   logic [DIGIT-1:0]   dots_q,   dots_d;
   logic               load_q,   load_d;
   logic [7:0]         seg_q,    seg_d;
   logic [DIGIT-1:0]   dig_q,    dig_d;

   logic [DIGIT-1:0]   lz_mask;
   logic               zero_run;
   logic [3:0]         nib;
   logic [7:0]         seg_raw;

   // A digit is blanked only if it and every more-significant digit are zero.
   always_comb begin
      lz_mask  = '0;
      zero_run = bus.blank_lz;
      for (int i = DIGIT - 1; i > 0; i--) begin
         zero_run   = zero_run & (shadow_q[i*4 +: 4] == 4'h0);
         lz_mask[i] = zero_run;
      end
   end

   always_comb begin
      idx_d    = idx_q;
      shadow_d = shadow_q;
      dots_d   = dots_q;
      load_d   = tick;
      seg_d    = seg_q;
      dig_d    = dig_q;
      nib      = shadow_q[int'(idx_q)*4 +: 4];
      seg_raw  = lz_mask[idx_q] ? 8'h00 : hex_to_seg(nib);

      if (tick) begin
         if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            shadow_d = bus.number;
            dots_d   = bus.dots;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      // Disabling clears immediately; re-enabling waits for the next digit load.
      if (!bus.en) begin
         seg_d = 8'h00;
         dig_d = '0;
      end else if (load_q) begin
         dig_d        = '0;
         dig_d[idx_q] = 1'b1;
         seg_d        = {seg_raw[7:1], dots_q[idx_q]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q    <= IDX_LAST;
         shadow_q <= '0;
         dots_q   <= '0;
         load_q   <= 1'b0;
         seg_q    <= 8'h00;
         dig_q    <= '0;
      end else begin
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         dots_q   <= dots_d;
         load_q   <= load_d;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
      end
   end

   assign bus.abcdefgh = seg_q;
   assign bus.digit    = dig_q;
endmodule
